// File: rtl/fifo_ptr_ctrl.sv
// Synchronous FIFO pointer/status controller for a dual-port RAM of depth 2**ADDR_W.
// Optional: define GRAY_PTR_EN to add registered Gray-coded copies of both pointers.
module fifo_ptr_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef GRAY_PTR_EN
  ,
  output logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr_gray
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT = PTR_W'(AE_LEVEL);

  generate
    if (ADDR_W < 2) begin : g_bad_addr_w
      $error("fifo_ptr_ctrl: ADDR_W must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
      $error("fifo_ptr_ctrl: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
      $error("fifo_ptr_ctrl: AE_LEVEL must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  // The extra wrap bit distinguishes full (MSBs differ) from empty (identical).
  assign full         = (wptr_reg[ADDR_W] != rptr_reg[ADDR_W]) &&
                        (wptr_reg[ADDR_W-1:0] == rptr_reg[ADDR_W-1:0]);
  assign empty        = (wptr_reg == rptr_reg);
  assign count        = wptr_reg - rptr_reg;
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign waddr        = wptr_reg[ADDR_W-1:0];
  assign raddr        = rptr_reg[ADDR_W-1:0];
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  always_comb begin
    wr_ack         = wr_en & ~full & ~clr;
    rd_ack         = rd_en & ~empty & ~clr;
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (clr) begin
      wptr_next      = '0;
      rptr_next      = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (wr_ack) wptr_next = wptr_reg + PTR_W'(1);
      if (rd_ack) rptr_next = rptr_reg + PTR_W'(1);
      overflow_next  = overflow_reg | (wr_en & full);
      underflow_next = underflow_reg | (rd_en & empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

`ifdef GRAY_PTR_EN
  // Gray is encoded from the next-state pointer so it lines up with the binary register.
  logic [PTR_W-1:0] wgray_next, rgray_next;
  logic [PTR_W-1:0] wptr_gray_reg, rptr_gray_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PTR_W - 1; gi++) begin : g_gray
      assign wgray_next[gi] = wptr_next[gi] ^ wptr_next[gi+1];
      assign rgray_next[gi] = rptr_next[gi] ^ rptr_next[gi+1];
    end
  endgenerate
  assign wgray_next[PTR_W-1] = wptr_next[PTR_W-1];
  assign rgray_next[PTR_W-1] = rptr_next[PTR_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_gray_reg <= '0;
      rptr_gray_reg <= '0;
    end else begin
      wptr_gray_reg <= wgray_next;
      rptr_gray_reg <= rgray_next;
    end
  end

  assign wptr_gray = wptr_gray_reg;
  assign rptr_gray = rptr_gray_reg;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: a vector table plus a random phase checked against an
// occupancy-count model, with expected post-edge state queued per cycle.
module tb_fifo_ptr_ctrl;
  localparam int ADDR_W   = 4;
  localparam int AF_LEVEL = 14;
  localparam int AE_LEVEL = 2;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, rd_en;
  logic [3:0] waddr, raddr;
  logic       wr_ack, rd_ack, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;
`ifdef GRAY_PTR_EN
  logic [4:0] wptr_gray, rptr_gray;
`endif

  fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
    .waddr(waddr), .raddr(raddr), .wr_ack(wr_ack), .rd_ack(rd_ack),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
`ifdef GRAY_PTR_EN
    , .wptr_gray(wptr_gray), .rptr_gray(rptr_gray)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] cnt;
    logic       full, empty, af, ae, ovf, unf;
    logic [3:0] wa, ra;
  } exp_t;

  typedef struct {
    logic rst_n, clr, wr, rd, chk_ack, wack, rack;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wa_t = 0;
  int   ra_t = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Status flags are derived from the expected occupancy alone.
  function automatic exp_t mk(input int cnt, input bit ovf, input bit unf, input int wa, input int ra);
    exp_t e;
    e.cnt   = cnt[4:0];
    e.full  = (cnt == DEPTH);
    e.empty = (cnt == 0);
    e.af    = (cnt >= AF_LEVEL);
    e.ae    = (cnt <= AE_LEVEL);
    e.ovf   = ovf;
    e.unf   = unf;
    e.wa    = wa[3:0];
    e.ra    = ra[3:0];
    return e;
  endfunction

  task automatic add(input bit r, input bit c, input bit w, input bit rd, input bit ca,
                     input bit wk, input bit rk, input int cnt, input bit ovf, input bit unf);
    vec_t v;
    if (!r || c) begin
      wa_t = 0;
      ra_t = 0;
    end else begin
      wa_t = (wa_t + int'(wk)) % DEPTH;
      ra_t = (ra_t + int'(rk)) % DEPTH;
    end
    v.rst_n = r; v.clr = c; v.wr = w; v.rd = rd;
    v.chk_ack = ca; v.wack = wk; v.rack = rk;
    v.e = mk(cnt, ovf, unf, wa_t, ra_t);
    vecs.push_back(v);
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb.pop_front();
    chk("count", count, e.cnt);
    chk("full", full, e.full);
    chk("empty", empty, e.empty);
    chk("almost_full", almost_full, e.af);
    chk("almost_empty", almost_empty, e.ae);
    chk("overflow", overflow, e.ovf);
    chk("underflow", underflow, e.unf);
    chk("waddr", waddr, e.wa);
    chk("raddr", raddr, e.ra);
  endtask

  // Called one time unit after a rising edge; acks are sampled mid-cycle.
  task automatic apply(input bit r, input bit c, input bit w, input bit rd, input bit ca,
                       input bit wk, input bit rk, input exp_t e);
    rst_n = r; clr = c; wr_en = w; rd_en = rd;
    #3;
    if (ca) begin
      chk("wr_ack", wr_ack, wk);
      chk("rd_ack", rd_ack, rk);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    int  m_cnt, m_wa, m_ra, pw, pr;
    bit  m_ovf, m_unf, c, w, rd, wk, rk;
`ifdef GRAY_PTR_EN
    logic [4:0] prev_g;
`endif
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(1, 0, 1, 0, 1, 1, 0, i, 0, 0);
    add(1, 0, 1, 1, 1, 0, 1, 15, 1, 0);      // full: read wins, write flags overflow
    add(1, 0, 0, 0, 1, 0, 0, 15, 1, 0);
    add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);       // clr with write request
    add(1, 0, 1, 1, 1, 1, 0, 1, 0, 1);       // empty: write wins, read flags underflow
    repeat (40) add(1, 0, 1, 1, 1, 1, 1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    for (int i = 1; i <= 9; i++) add(1, 0, 1, 0, 1, 1, 0, i, 0, 1);
    add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(1, 0, 1, 0, 1, 1, 0, i, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);       // reset mid-burst
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 0, 1);

    @(posedge clk);
    #1;
    foreach (vecs[i])
      apply(vecs[i].rst_n, vecs[i].clr, vecs[i].wr, vecs[i].rd,
            vecs[i].chk_ack, vecs[i].wack, vecs[i].rack, vecs[i].e);
    $display("[TB] vector table: %0d cycles applied", vecs.size());

    m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      c  = (n == 0) || ($urandom_range(0, 63) == 0);
      pw = ((n / 40) % 2 == 0) ? 80 : 25;
      pr = 105 - pw;
      w  = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < pr);
      wk = w && !c && (m_cnt < DEPTH);
      rk = rd && !c && (m_cnt > 0);
      if (c) begin
        m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
        m_ovf = m_ovf | (w && m_cnt == DEPTH);
        m_unf = m_unf | (rd && m_cnt == 0);
        m_cnt = m_cnt + int'(wk) - int'(rk);
        m_wa  = (m_wa + int'(wk)) % DEPTH;
        m_ra  = (m_ra + int'(rk)) % DEPTH;
      end
      apply(1, c, w, rd, 1, wk, rk, mk(m_cnt, m_ovf, m_unf, m_wa, m_ra));
    end
    $display("[TB] random phase: 400 cycles applied");

`ifdef GRAY_PTR_EN
    apply(1, 1, 0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0));
    chk("wptr_gray_clr", wptr_gray, 0);
    prev_g = wptr_gray;
    for (int i = 1; i <= 16; i++) begin
      apply(1, 0, 1, 0, 1, 1, 0, mk(i, 0, 0, i % DEPTH, 0));
      chk("gray_one_bit_step", $countones(prev_g ^ wptr_gray), 1);
      prev_g = wptr_gray;
      if (i == 5)  chk("wptr_gray_at_5", wptr_gray, 7);
      if (i == 16) chk("wptr_gray_at_16", wptr_gray, 24);
    end
    chk("rptr_gray_idle", rptr_gray, 0);
    $display("[TB] gray sequence: 16 writes applied");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
